// File: rtl/fp_pkg.sv
// Shared definitions for the small-float decode/encode blocks: default field widths
// and the conversion FSM state type.
package fp_pkg;

    localparam int FP_EXP_W  = 3;
    localparam int FP_FRAC_W = 4;
    localparam int FP_OUT_W  = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SIGN,
        DONE
    } fp_state_t;

endpackage

// File: rtl/fp_decode.sv
// Sequential small-float to linear converter: D = (-1)^S * F * 2^E, one shift per
// clock, then a two's-complement sign stage, then a ready/valid hold.
module fp_decode
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int OUT_W  = FP_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     S,
    input  logic [EXP_W-1:0]         E,
    input  logic [FRAC_W-1:0]        F,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  D
);

    fp_state_t          state;
    logic               s_q;
    logic [EXP_W-1:0]   cnt;
    logic [OUT_W-1:0]   mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_q   <= 1'b0;
            cnt   <= '0;
            mag   <= '0;
            D     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_q   <= S;
                        cnt   <= E;
                        mag   <= OUT_W'(F);
                        state <= SHIFT;
                    end
                end
                // One doubling per clock; cnt counts the remaining exponent.
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= SIGN;
                    end
                end
                // Negating a zero magnitude wraps back to zero, so no negative zero.
                SIGN: begin
                    D     <= s_q ? $signed(~mag + 1'b1) : $signed(mag);
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_decode.sv
// Bench for fp_decode: directed corner cases, backpressure, reset abort and a full
// sweep of all (S,E,F) codes against an arithmetic reference model.
module tb_fp_decode;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               S = 1'b0;
    logic [2:0]         E = '0;
    logic [3:0]         F = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [11:0] D;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int val;
        int acc;
        int e;
    } exp_t;
    exp_t q[$];

    fp_decode #(.EXP_W(3), .FRAC_W(4), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready), .D(D)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(input bit s, input int e, input int f);
        int m;
        m = f * (1 << e);
        return s ? -m : m;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Compare process: reference queue of accepted inputs, checked on every cycle.
    logic               ov_prev = 1'b0;
    logic signed [11:0] d_prev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_D", int'(D), 0);
        end else begin
            check("ready_valid_exclusive", int'(in_ready && out_valid), 0);
            if (out_valid && !ov_prev) begin
                check("result_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    check("model_D", int'(D), q[0].val);
                    check("latency", cyc - q[0].acc, q[0].e + 2);
                end
            end else begin
                check("D_stable", int'(D), int'(d_prev));
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready)
                q.push_back('{model(S, int'(E), int'(F)), cyc + 1, int'(E)});
        end
        ov_prev = out_valid;
        d_prev  = D;
    end

    task automatic xfer(input bit s, input int e, input int f, input int req, input bit rnd);
        int to;
        @(posedge clk); #1;
        S = s; E = 3'(e); F = 4'(f); in_valid = 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        to = 0;
        while (!in_ready && to < 50) begin
            @(posedge clk); #1; to++;
        end
        if (to >= 50) check("accept_timeout", 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
        to = 0;
        while (!out_valid && to < 20) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; to++;
        end
        if (to >= 20) check("out_valid_timeout", 1, 0);
        else check("xfer_D", int'(D), req);
        to = 0;
        while (out_valid && to < 50) begin
            if (rnd && to < 10) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            @(posedge clk); #1; to++;
        end
        if (to >= 50) check("drain_timeout", 1, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int to;
        logic [11:0] x;

        #12;
        check("init_in_ready", int'(in_ready), 1);
        check("init_out_valid", int'(out_valid), 0);
        check("init_D", int'(D), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Hand-computed expectations.
        xfer(1'b0, 0, 0, 0, 1'b0);
        xfer(1'b0, 7, 15, 1920, 1'b0);
        xfer(1'b1, 3, 5, -40, 1'b0);
        x = D;
        check("neg40_hex", int'(x), 12'hFD8);
        xfer(1'b1, 7, 15, -1920, 1'b0);
        x = D;
        check("neg1920_hex", int'(x), 12'h880);
        xfer(1'b1, 4, 0, 0, 1'b0);

        // Backpressure: result held while new data is offered.
        @(posedge clk); #1;
        S = 1'b0; E = 3'd2; F = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        to = 0;
        while (!out_valid && to < 20) begin
            @(posedge clk); #1; to++;
        end
        check("bp_reached_done", int'(out_valid), 1);
        S = 1'b1; E = 3'd7; F = 4'd15; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_D", int'(D), 12);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", int'(in_ready), 1);
        check("bp_idle_valid", int'(out_valid), 0);
        check("bp_idle_D", int'(D), 12);
        @(posedge clk); #1;
        check("bp_next_taken", int'(in_ready), 0);
        in_valid = 1'b0;
        to = 0;
        while (!out_valid && to < 20) begin
            @(posedge clk); #1; to++;
        end
        check("bp_next_D", int'(D), -1920);
        @(posedge clk); #1;

        // Reset in the middle of a long shift.
        S = 1'b0; E = 3'd6; F = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("rst_now_in_ready", int'(in_ready), 1);
        check("rst_now_out_valid", int'(out_valid), 0);
        check("rst_now_D", int'(D), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        to = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) to++;
        end
        check("no_stale_result", to, 0);

        // Every code, with random consumer stalls.
        for (int i = 0; i < 256; i++) begin
            v = model(i[7], (i >> 4) & 7, i & 15);
            xfer(i[7], (i >> 4) & 7, i & 15, v, 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            int s, e, f;
            s = $urandom_range(0, 1); e = $urandom_range(0, 7); f = $urandom_range(0, 15);
            xfer(1'(s), e, f, model(1'(s), e, f), 1'b1);
        end

        repeat (4) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
